// File: rtl/disp_share_arbiter_if.sv
// Display-share bus: client requests/digits in, owner grant and muxed digits out.
interface disp_share_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]      req;
  logic [16*NREQ-1:0]   data;
  logic [4*NREQ-1:0]    dp;
  logic [NREQ-1:0]      grant;
  logic [3:0]           hex3;
  logic [3:0]           hex2;
  logic [3:0]           hex1;
  logic [3:0]           hex0;
  logic [3:0]           dp_out;
  logic                 busy;

  // Requesting side: drives requests and digits, observes the display outputs.
  modport master (
    output req, data, dp,
    input  grant, hex3, hex2, hex1, hex0, dp_out, busy
  );

  // Arbiter side.
  modport slave (
    input  req, data, dp,
    output grant, hex3, hex2, hex1, hex0, dp_out, busy
  );
endinterface

// File: rtl/disp_share_arbiter.sv
// Round-robin time-sharing of one 4-digit seven-segment display between NREQ
// clients. An owner keeps the display for at least SLOT_TICKS dwell ticks
// while others wait; a GAP_CYCLES blank separates consecutive owners.
// Optional build macro DISP_ARB_PREEMPT_EN: requester 0 becomes high priority
// (preempts other owners immediately and wins arbitration outright).
module disp_share_arbiter #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned TICK_DIV   = 12_500_000,
  parameter int unsigned SLOT_TICKS = 8,
  parameter int unsigned GAP_CYCLES = 2,
  parameter logic [15:0] IDLE_HEX   = 16'h0000
) (
  input  logic                 clk,
  input  logic                 reset,
  disp_share_arbiter_if.slave  bus
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW_W  = $clog2(SLOT_TICKS + 1);
  localparam int unsigned GP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHOW,
    S_GAP
  } state_t;

  state_t            r_state;
  logic [NREQ-1:0]   r_grant;
  logic [PTR_W-1:0]  r_ptr;
  logic [PRE_W-1:0]  r_presc;
  logic [DW_W-1:0]   r_dwell;
  logic [GP_W-1:0]   r_gap;

  state_t            w_state_nx;
  logic [NREQ-1:0]   w_grant_nx;
  logic [PTR_W-1:0]  w_ptr_nx;
  logic [PRE_W-1:0]  w_presc_nx;
  logic [DW_W-1:0]   w_dwell_nx;
  logic [GP_W-1:0]   w_gap_nx;

  logic              w_found;
  logic [PTR_W-1:0]  w_pick;
  logic [PTR_W-1:0]  w_sel;
  logic              w_tick;
  logic              w_slot_done;
  logic              w_owner_req;
  logic              w_others;
  logic              w_leave;
  logic [15:0]       w_hex;
  logic [3:0]        w_dp;

  // Index of the requester `off` positions after `base`, modulo NREQ.
  function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] base,
                                               input int unsigned off);
    int unsigned s;
    s = (32'(base) + off) % NREQ;
    return PTR_W'(s);
  endfunction

  // Round-robin search starting just after the last owner.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      if (!w_found && bus.req[rr_idx(r_ptr, i)]) begin
        w_found = 1'b1;
        w_pick  = rr_idx(r_ptr, i);
      end
    end
  end

  assign w_tick      = (r_presc == PRE_W'(TICK_DIV - 1));
  assign w_slot_done = (r_dwell == DW_W'(SLOT_TICKS));
  assign w_owner_req = |(bus.req & r_grant);
  assign w_others    = |(bus.req & ~r_grant);

  // Decide whether the current owner must release the display this cycle.
  always_comb begin
    w_leave = 1'b0;
    if (!w_owner_req) begin
      w_leave = 1'b1;
    end
`ifdef DISP_ARB_PREEMPT_EN
    else if (!r_grant[0] && bus.req[0]) begin
      w_leave = 1'b1;
    end else if (!r_grant[0] && w_slot_done && w_others) begin
      w_leave = 1'b1;
    end
`else
    else if (w_slot_done && w_others) begin
      w_leave = 1'b1;
    end
`endif
  end

  // Next-state and next-register logic for the IDLE/SHOW/GAP controller.
  always_comb begin
    w_state_nx = r_state;
    w_grant_nx = r_grant;
    w_ptr_nx   = r_ptr;
    w_presc_nx = r_presc;
    w_dwell_nx = r_dwell;
    w_gap_nx   = r_gap;
    w_sel      = w_pick;
`ifdef DISP_ARB_PREEMPT_EN
    if (bus.req[0]) w_sel = '0;
`endif
    case (r_state)
      S_IDLE: begin
        if (|bus.req) begin
          w_grant_nx        = '0;
          w_grant_nx[w_sel] = 1'b1;
          w_ptr_nx          = w_sel;
          w_presc_nx        = '0;
          w_dwell_nx        = '0;
          w_state_nx        = S_SHOW;
        end
      end
      S_SHOW: begin
        w_presc_nx = w_tick ? '0 : r_presc + 1'b1;
        if (w_tick && !w_slot_done) w_dwell_nx = r_dwell + 1'b1;
        if (w_leave) begin
          w_grant_nx = '0;
          w_gap_nx   = '0;
          w_state_nx = S_GAP;
        end
      end
      S_GAP: begin
        if (r_gap == GP_W'(GAP_CYCLES - 1)) w_state_nx = S_IDLE;
        else                                w_gap_nx   = r_gap + 1'b1;
      end
      default: begin
        w_grant_nx = '0;
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // Controller registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_ptr   <= PTR_W'(NREQ - 1);
      r_presc <= '0;
      r_dwell <= '0;
      r_gap   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_grant <= w_grant_nx;
      r_ptr   <= w_ptr_nx;
      r_presc <= w_presc_nx;
      r_dwell <= w_dwell_nx;
      r_gap   <= w_gap_nx;
    end
  end

  // Zero-latency output mux from the registered one-hot grant.
  always_comb begin
    w_hex = IDLE_HEX;
    w_dp  = 4'b1111;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (r_grant[k]) begin
        w_hex = bus.data[16*k +: 16];
        w_dp  = bus.dp[4*k +: 4];
      end
    end
  end

  assign bus.grant  = r_grant;
  assign bus.hex3   = w_hex[15:12];
  assign bus.hex2   = w_hex[11:8];
  assign bus.hex1   = w_hex[7:4];
  assign bus.hex0   = w_hex[3:0];
  assign bus.dp_out = w_dp;
  assign bus.busy   = (r_state == S_SHOW);

endmodule

// File: tb/tb_disp_share_arbiter.sv
// Scoreboard bench for disp_share_arbiter: a cycle-level reference model of
// the sharing rules pushes the expected outputs each cycle; a monitor on the
// falling edge pops and compares. Honours DISP_ARB_PREEMPT_EN like the DUT.
module tb_disp_share_arbiter;
  localparam int unsigned NREQ       = 4;
  localparam int unsigned TICK_DIV   = 4;
  localparam int unsigned SLOT_TICKS = 3;
  localparam int unsigned GAP_CYCLES = 2;
  localparam logic [15:0] IDLE_HEX   = 16'h0000;
  localparam int          SLOT_CYC   = SLOT_TICKS * TICK_DIV;

  typedef struct packed {
    logic [NREQ-1:0] grant;
    logic [15:0]     hex;
    logic [3:0]      dp;
    logic            busy;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  disp_share_arbiter_if #(.NREQ(NREQ)) bus ();

  disp_share_arbiter #(
    .NREQ(NREQ), .TICK_DIV(TICK_DIV), .SLOT_TICKS(SLOT_TICKS),
    .GAP_CYCLES(GAP_CYCLES), .IDLE_HEX(IDLE_HEX)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  logic [16*NREQ-1:0] nx_data;
  logic [4*NREQ-1:0]  nx_dp;

  // Reference model: phase 0 = nobody, 1 = showing, 2 = blank gap.
  int m_phase, m_owner, m_last, m_elapsed, m_gap;

  task automatic model_reset();
    m_phase = 0; m_owner = -1; m_last = NREQ - 1; m_elapsed = 0; m_gap = 0;
  endtask

  task automatic model_step();
    bit leave;
    bit others;
    case (m_phase)
      0: begin
        if (bus.req != '0) begin
          m_owner = -1;
`ifdef DISP_ARB_PREEMPT_EN
          if (bus.req[0]) m_owner = 0;
`endif
          for (int i = 1; i <= NREQ && m_owner < 0; i++) begin
            int c;
            c = (m_last + i) % NREQ;
            if (bus.req[c]) m_owner = c;
          end
          m_last = m_owner; m_elapsed = 0; m_phase = 1;
        end
      end
      1: begin
        others = 0;
        for (int i = 0; i < NREQ; i++) if (i != m_owner && bus.req[i]) others = 1;
        leave = 0;
        if (!bus.req[m_owner]) leave = 1;
`ifdef DISP_ARB_PREEMPT_EN
        else if (m_owner != 0 && bus.req[0]) leave = 1;
        else if (m_owner != 0 && m_elapsed >= SLOT_CYC && others) leave = 1;
`else
        else if (m_elapsed >= SLOT_CYC && others) leave = 1;
`endif
        if (leave) begin
          m_owner = -1; m_phase = 2; m_gap = GAP_CYCLES;
        end else if (m_elapsed < SLOT_CYC) begin
          m_elapsed++;
        end
      end
      default: begin
        m_gap--;
        if (m_gap == 0) m_phase = 0;
      end
    endcase
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.grant = '0;
    e.hex   = IDLE_HEX;
    e.dp    = 4'b1111;
    e.busy  = (m_phase == 1);
    if (m_owner >= 0) begin
      e.grant[m_owner] = 1'b1;
      e.hex = bus.data[16*m_owner +: 16];
      e.dp  = bus.dp[4*m_owner +: 4];
    end
    return e;
  endfunction

  // One clock: advance model on the edge, apply new inputs, queue expectation.
  task automatic cycle(input logic [NREQ-1:0] rq, input logic rs);
    @(posedge clk);
    #1;
    if (!reset) model_step();
    reset    = rs;
    bus.req  = rq;
    bus.data = nx_data;
    bus.dp   = nx_dp;
    if (rs) model_reset();
    #1;
    sb.push_back(model_out());
  endtask

  task automatic hold(input logic [NREQ-1:0] rq, input int n);
    for (int i = 0; i < n; i++) cycle(rq, 1'b0);
  endtask

  // Monitor: compare the DUT outputs against the queued expectation.
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a.grant = bus.grant;
        a.hex   = {bus.hex3, bus.hex2, bus.hex1, bus.hex0};
        a.dp    = bus.dp_out;
        a.busy  = bus.busy;
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL outputs @%0t: got grant=%b hex=%h dp=%b busy=%b, expected grant=%b hex=%h dp=%b busy=%b",
                   $time, a.grant, a.hex, a.dp, a.busy, e.grant, e.hex, e.dp, e.busy);
        end
      end
    end
  end

  // Stimulus: directed scenarios, then randomized traffic with occasional resets.
  initial begin
    logic [NREQ-1:0] rq;
    reset    = 1'b1;
    bus.req  = '0;
    nx_data  = '0;
    nx_dp    = '1;
    bus.data = nx_data;
    bus.dp   = nx_dp;
    model_reset();

    cycle('0, 1'b1);
    cycle('0, 1'b1);
    hold('0, 2);

    // Single requester holds indefinitely; owner data changes show at once.
    nx_data[47:32] = 16'h1234;
    nx_dp[11:8]    = 4'b1011;
    hold(4'b0100, 100);
    nx_data[47:32] = 16'hBEEF;
    hold(4'b0100, 5);
    hold(4'b0000, 6);

    // Two requesters from a fresh reset rotate 1 -> 3 -> 1.
    nx_data = {16'hA3A3, 16'hC2C2, 16'h1B1B, 16'h0F0F};
    nx_dp   = 16'b0111_1011_1101_1110;
    cycle('0, 1'b1);
    hold(4'b1010, 40);
    hold(4'b1000, 20);

    // Reset mid-SHOW brings the pointer back so requester 0 wins.
    cycle(4'b1000, 1'b1);
    hold(4'b1001, 20);

    // Owner drops early with nobody waiting.
    hold(4'b0000, 6);
    hold(4'b0010, 6);
    hold(4'b0000, 6);

    // Requester 0 arrives while 2 owns the display.
    hold(4'b0100, 2);
    hold(4'b0101, 30);
    hold(4'b0000, 5);

    // Randomized traffic.
    rq = '0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) rq[$urandom_range(0, NREQ-1)] ^= 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        int k;
        k = $urandom_range(0, NREQ-1);
        nx_data[16*k +: 16] = 16'($urandom);
        nx_dp[4*k +: 4]     = 4'($urandom);
      end
      cycle(rq, ($urandom_range(0, 399) == 0));
    end
    hold('0, 3);

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
